// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg
// Shared TileLink-UL definitions for the A-channel FIFO and its checker.
// The data width comes from RISCV_FORMAL_XLEN. If the harness does not
// define that macro, it falls back to 64 bits.
// Contents:
//   - A/D opcode constants
//   - tl_a_beat_t, one full A-channel beat
//   - tl_a_opcode_ok(), which accepts only the opcodes a UL responder handles

`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 64
`endif

package tl_ul_pkg;

    localparam int TL_XLEN  = `RISCV_FORMAL_XLEN;
    localparam int TL_MASKW = TL_XLEN / 8;

    // A-channel opcodes
    localparam logic [2:0] TL_A_PUTFULLDATA    = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIALDATA = 3'd1;
    localparam logic [2:0] TL_A_GET            = 3'd4;
    // D-channel opcodes
    localparam logic [2:0] TL_D_ACCESSACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESSACKDATA  = 3'd1;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [3:0]          size;
        logic                source;
        logic [31:0]         address;
        logic [TL_MASKW-1:0] mask;
        logic [TL_XLEN-1:0]  data;
    } tl_a_beat_t;

    function automatic logic tl_a_opcode_ok(input logic [2:0] op);
        return (op == TL_A_PUTFULLDATA) || (op == TL_A_PUTPARTIALDATA) ||
               (op == TL_A_GET);
    endfunction

endpackage

// File: rtl/tl_a_fifo_check.sv
// tl_a_fifo_check
// Protocol monitor for the input side of tilelink_a_fifo.
// proto_err is sticky until reset. It is set for:
//   - an accepted beat with an illegal opcode, a misaligned address,
//     an oversize transfer, or a Get whose mask is not exactly the
//     addressed bytes;
//   - a stalled beat (valid && !ready last cycle) that drops valid or
//     changes payload this cycle.
// Ports:
//   clock, reset   single clock; synchronous active-high reset
//   in_valid       upstream valid
//   in_ready       FIFO ready
//   in_beat        upstream payload
//   proto_err      sticky violation flag (registered)

module tl_a_fifo_check
    import tl_ul_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_ready,
    input  tl_a_beat_t in_beat,
    output logic       proto_err
);

    localparam int LB = $clog2(TL_MASKW);   // log2 of the bus width in bytes

    logic                proto_err_q, proto_err_d;
    logic                prev_valid_q, prev_valid_d;
    logic                prev_ready_q, prev_ready_d;
    tl_a_beat_t          prev_beat_q, prev_beat_d;

    logic                bad_op, bad_size, bad_align, bad_mask;
    logic                accept_bad, stall_bad;
    logic [TL_MASKW-1:0] need_mask;
    int                  off, nb;

    always_comb begin
        bad_op    = !tl_a_opcode_ok(in_beat.opcode);
        bad_size  = int'(in_beat.size) > LB;
        bad_align = (in_beat.address & ((32'd1 << in_beat.size) - 32'd1)) != 32'd0;

        // Bytes touched by the beat, within one bus word. This is only
        // meaningful when size and alignment are legal. Otherwise those
        // flags already fire.
        off       = int'(in_beat.address[LB-1:0]);
        nb        = 1 << in_beat.size;
        need_mask = '0;
        for (int i = 0; i < TL_MASKW; i++) begin
            if (i >= off && i < off + nb) need_mask[i] = 1'b1;
        end
        bad_mask  = (in_beat.opcode == TL_A_GET) && (in_beat.mask != need_mask);

        accept_bad = in_valid && in_ready &&
                     (bad_op || bad_size || bad_align || bad_mask);
        stall_bad  = prev_valid_q && !prev_ready_q &&
                     (!in_valid || (in_beat != prev_beat_q));

        proto_err_d  = proto_err_q || accept_bad || stall_bad;
        prev_valid_d = in_valid;
        prev_ready_d = in_ready;
        prev_beat_d  = in_beat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            proto_err_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
        end else begin
            proto_err_q  <= proto_err_d;
            prev_valid_q <= prev_valid_d;
            prev_ready_q <= prev_ready_d;
        end
        prev_beat_q <= prev_beat_d;
    end

    assign proto_err = proto_err_q;

`ifdef FORMAL
    always_ff @(posedge clock) begin
        if (!reset) assert (!proto_err_q);
    end
`endif

endmodule

// File: rtl/tilelink_a_fifo.sv
// tilelink_a_fifo
// DEPTH-entry in-order FIFO on the TileLink-UL A channel. It sits between
// the tile master port and the downstream responder.
// There is no bypass: a beat written this cycle is visible next cycle.
// in_a_ready depends only on occupancy, so no combinational path runs
// from out_a_ready to in_a_ready.
// Optional checker: define TL_A_FIFO_CHECK_EN to instantiate
// tl_a_fifo_check. Without it, proto_err is tied low.
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   in_a_*                upstream A channel (valid/ready + bits)
//   out_a_*               downstream A channel; bits are the head entry
//   level                 occupied entries
//   proto_err             sticky protocol violation flag

module tilelink_a_fifo
    import tl_ul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = `RISCV_FORMAL_XLEN
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_a_valid,
    output logic                       in_a_ready,
    input  logic [2:0]                 in_a_bits_opcode,
    input  logic [2:0]                 in_a_bits_param,
    input  logic [3:0]                 in_a_bits_size,
    input  logic                       in_a_bits_source,
    input  logic [31:0]                in_a_bits_address,
    input  logic [XLEN/8-1:0]          in_a_bits_mask,
    input  logic [XLEN-1:0]            in_a_bits_data,
    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [2:0]                 out_a_bits_opcode,
    output logic [2:0]                 out_a_bits_param,
    output logic [3:0]                 out_a_bits_size,
    output logic                       out_a_bits_source,
    output logic [31:0]                out_a_bits_address,
    output logic [XLEN/8-1:0]          out_a_bits_mask,
    output logic [XLEN-1:0]            out_a_bits_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       proto_err
);

    localparam int              PW   = $clog2(DEPTH);
    localparam int              CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    tl_a_beat_t        mem_q [DEPTH];   // storage is intentionally not reset
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    tl_a_beat_t        in_beat, head;

    assign in_beat = '{opcode:  in_a_bits_opcode,
                       param:   in_a_bits_param,
                       size:    in_a_bits_size,
                       source:  in_a_bits_source,
                       address: in_a_bits_address,
                       mask:    in_a_bits_mask,
                       data:    in_a_bits_data};

    // Handshakes are forced low while reset is asserted, so nothing is
    // pushed or popped in a reset cycle.
    assign in_a_ready  = (count_q != FULL) && !reset;
    assign out_a_valid = (count_q != '0) && !reset;
    assign push        = in_a_valid && in_a_ready;
    assign pop         = out_a_valid && out_a_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_beat;
    end

    assign head               = mem_q[rd_ptr_q];
    assign out_a_bits_opcode  = head.opcode;
    assign out_a_bits_param   = head.param;
    assign out_a_bits_size    = head.size;
    assign out_a_bits_source  = head.source;
    assign out_a_bits_address = head.address;
    assign out_a_bits_mask    = head.mask;
    assign out_a_bits_data    = head.data;
    assign level              = count_q;

`ifdef TL_A_FIFO_CHECK_EN
    tl_a_fifo_check u_check (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_a_valid),
        .in_ready  (in_a_ready),
        .in_beat   (in_beat),
        .proto_err (proto_err)
    );
`ifdef FORMAL
    always_ff @(posedge clock) begin
        if (!reset) assert (count_q <= FULL);
    end
`endif
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_tilelink_a_fifo.sv
module tb_tilelink_a_fifo;
    import tl_ul_pkg::*;

`ifdef TL_A_FIFO_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic                in_a_valid, in_a_ready;
    logic [2:0]          in_a_bits_opcode, in_a_bits_param;
    logic [3:0]          in_a_bits_size;
    logic                in_a_bits_source;
    logic [31:0]         in_a_bits_address;
    logic [TL_MASKW-1:0] in_a_bits_mask;
    logic [TL_XLEN-1:0]  in_a_bits_data;
    logic                out_a_valid, out_a_ready;
    logic [2:0]          out_a_bits_opcode, out_a_bits_param;
    logic [3:0]          out_a_bits_size;
    logic                out_a_bits_source;
    logic [31:0]         out_a_bits_address;
    logic [TL_MASKW-1:0] out_a_bits_mask;
    logic [TL_XLEN-1:0]  out_a_bits_data;
    logic [2:0]          level;
    logic                proto_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clock = ~clock;

    tilelink_a_fifo #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_param(in_a_bits_param),
        .in_a_bits_size(in_a_bits_size), .in_a_bits_source(in_a_bits_source),
        .in_a_bits_address(in_a_bits_address), .in_a_bits_mask(in_a_bits_mask),
        .in_a_bits_data(in_a_bits_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data),
        .level(level), .proto_err(proto_err)
    );

    typedef struct {
        bit          v;
        logic [31:0] addr;
        bit          rdy;
        bit          e_ir;
        bit          e_ov;
        int          e_lvl;
        logic [31:0] e_head;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [TL_MASKW-1:0] mask_for(input logic [31:0] a, input int sz);
        logic [TL_MASKW-1:0] m = '0;
        int off = int'(a % TL_MASKW);
        int nb  = 1 << sz;
        for (int i = 0; i < TL_MASKW; i++) if (i >= off && i < off + nb) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [TL_XLEN-1:0] data_for(input logic [31:0] a);
        return TL_XLEN'({a, ~a});
    endfunction

    function automatic vec_t mk(bit v, logic [31:0] a, bit rdy, bit ir, bit ov,
                                int lvl, logic [31:0] hd);
        vec_t r;
        r.v = v; r.addr = a; r.rdy = rdy; r.e_ir = ir; r.e_ov = ov;
        r.e_lvl = lvl; r.e_head = hd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input int sz,
                         input logic [31:0] a, input bit rdy);
        in_a_valid        = v;
        in_a_bits_opcode  = op;
        in_a_bits_param   = 3'd0;
        in_a_bits_size    = 4'(sz);
        in_a_bits_source  = 1'b0;
        in_a_bits_address = a;
        in_a_bits_mask    = mask_for(a, sz);
        in_a_bits_data    = data_for(a);
        out_a_ready       = rdy;
    endtask

    task automatic chk_head(input string name, input logic [31:0] a);
        chk({name, "_addr"}, out_a_bits_address, a);
        chk({name, "_data"}, out_a_bits_data, data_for(a));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] a;

        // reset state
        reset = 1'b1;
        drive(1'b0, TL_A_GET, 2, 32'h0, 1'b0);
        tick(); tick();
        chk("rst_ir", in_a_ready, 0);
        chk("rst_ov", out_a_valid, 0);
        chk("rst_lvl", level, 0);
        chk("rst_perr", proto_err, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ir", in_a_ready, 1);

        // fill / full+pop / drain table. Expected values are pre-edge state.
        vecs[0]  = mk(1, 32'h80000000, 0, 1, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h80000004, 0, 1, 1, 1, 32'h80000000);
        vecs[2]  = mk(1, 32'h80000008, 0, 1, 1, 2, 32'h80000000);
        vecs[3]  = mk(1, 32'h8000000C, 0, 1, 1, 3, 32'h80000000);
        vecs[4]  = mk(1, 32'h80000010, 0, 0, 1, 4, 32'h80000000);
        vecs[5]  = mk(1, 32'h80000010, 0, 0, 1, 4, 32'h80000000);
        vecs[6]  = mk(1, 32'h80000010, 1, 0, 1, 4, 32'h80000000); // pop at full
        vecs[7]  = mk(1, 32'h80000010, 0, 1, 1, 3, 32'h80000004); // ready next cycle
        vecs[8]  = mk(0, 32'h0,        0, 0, 1, 4, 32'h80000004);
        vecs[9]  = mk(0, 32'h0,        1, 1, 1, 4, 32'h80000004);
        vecs[9].e_ir = 0;
        vecs[10] = mk(0, 32'h0,        1, 1, 1, 3, 32'h80000008);
        vecs[11] = mk(0, 32'h0,        1, 1, 1, 2, 32'h8000000C);
        vecs[12] = mk(0, 32'h0,        1, 1, 1, 1, 32'h80000010);
        vecs[13] = mk(0, 32'h0,        1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, TL_A_GET, 2, vecs[i].addr, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_ir", i), in_a_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_ov", i), out_a_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_lvl", i), level, vecs[i].e_lvl);
            chk($sformatf("v%0d_perr", i), proto_err, 0);
            if (vecs[i].e_ov) chk_head($sformatf("v%0d", i), vecs[i].e_head);
            tick();
        end

        // sustained push+pop at level 2, across pointer wrap
        for (int i = 0; i < 2; i++) begin
            a = 32'h80001000 + 32'(4 * i);
            drive(1'b1, TL_A_GET, 2, a, 1'b0);
            q.push_back(a);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            a = 32'h80001008 + 32'(4 * k);
            drive(1'b1, TL_A_GET, 2, a, 1'b1);
            #1;
            chk($sformatf("pp%0d_lvl", k), level, 2);
            chk($sformatf("pp%0d_ov", k), out_a_valid, 1);
            chk_head($sformatf("pp%0d", k), q[0]);
            tick();
            void'(q.pop_front());
            q.push_back(a);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, TL_A_GET, 2, 32'h0, 1'b1);
            #1;
            chk_head($sformatf("ppd%0d", k), q[0]);
            tick();
            void'(q.pop_front());
        end
        chk("pp_empty", level, 0);

        // stall stability: PutFull, size 3, source 1
        drive(1'b1, TL_A_PUTFULLDATA, 3, 32'h80000040, 1'b0);
        in_a_bits_source = 1'b1;
        tick();
        drive(1'b0, TL_A_GET, 2, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("st%0d_ov", k), out_a_valid, 1);
            chk($sformatf("st%0d_op", k), out_a_bits_opcode, TL_A_PUTFULLDATA);
            chk($sformatf("st%0d_sz", k), out_a_bits_size, 3);
            chk($sformatf("st%0d_src", k), out_a_bits_source, 1);
            chk($sformatf("st%0d_mask", k), out_a_bits_mask, {TL_MASKW{1'b1}});
            chk_head($sformatf("st%0d", k), 32'h80000040);
            tick();
        end
        out_a_ready = 1'b1;
        tick();
        chk("st_drained", level, 0);

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, TL_A_GET, 2, 32'h80002000 + 32'(4 * i), 1'b0);
            tick();
        end
        chk("mr_lvl3", level, 3);
        reset = 1'b1;
        #1;
        chk("mr_ir_in_rst", in_a_ready, 0);
        chk("mr_ov_in_rst", out_a_valid, 0);
        tick();
        reset = 1'b0;
        drive(1'b0, TL_A_GET, 2, 32'h0, 1'b0);
        #1;
        chk("mr_lvl", level, 0);
        chk("mr_ir", in_a_ready, 1);
        chk("mr_ov", out_a_valid, 0);

        // checker: misaligned Get
        drive(1'b1, TL_A_GET, 2, 32'h80000002, 1'b1);
        tick();
        drive(1'b0, TL_A_GET, 2, 32'h0, 1'b1);
        #1;
        chk("ck_align", proto_err, CHK_EN);
        tick(); tick();
        chk("ck_sticky", proto_err, CHK_EN);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ck_rst_clr", proto_err, 0);

        // checker: opcode 5
        drive(1'b1, 3'd5, 2, 32'h80000004, 1'b1);
        tick();
        drive(1'b0, TL_A_GET, 2, 32'h0, 1'b1);
        #1;
        chk("ck_opcode", proto_err, CHK_EN);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ck_rst_clr2", proto_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
